dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Multi-cycle data-memory controller that sits directly downstream of the MIPS datapath. It consumes `aluout` (address), `writedata` and the control unit's `memread`/`memwrite`, and runs a req/ack transaction on an external data-memory bus. While the transaction is in flight it holds the datapath with `stall`. It returns `readdata` to the datapath's result mux.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `TIMEOUT`, default 15: maximum cycles to wait for `mem_ack` (used only with the macro).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `memread`  in  1  load request from the control unit.
- `memwrite`  in  1  store request from the control unit.
- `addr`  in  AW  byte address (datapath `aluout`).
- `writedata`  in  DW  store data (datapath `writedata`).
- `readdata`  out  DW  load data to the datapath; registered.
- `stall`  out  1  freezes PC and register writes; combinational.
- `err`  out  1  one-cycle pulse on misaligned access (or timeout).
- `mem_req`  out  1  bus request; registered.
- `mem_we`  out  1  bus write enable; registered.
- `mem_addr`  out  AW  word-aligned bus address; registered.
- `mem_wdata`  out  DW  bus write data; registered.
- `mem_rdata`  in  DW  bus read data; valid when `mem_ack` is 1.
- `mem_ack`  in  1  bus completion; one-cycle pulse.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - On `memread|memwrite`: latch `addr`, `writedata` and direction, drive `mem_req`=1, go to REQ.
  - If `memread` and `memwrite` are both 1, the access is a write.
- **Misaligned access** (`addr[1:0]` != 0, detected in IDLE)
  - No bus transaction.
  - `err` pulses, `readdata`=0, go directly to DONE.
- **REQ**
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable until `mem_ack`.
  - On `mem_ack`: capture `mem_rdata` into `readdata` (reads only; writes leave `readdata` unchanged), drop `mem_req`, go to DONE.
- **DONE**
  - `stall`=0, so the datapath completes the instruction this cycle.
  - Unconditionally return to IDLE. The next access is only recognised in IDLE.
- **stall** = (IDLE & (`memread`|`memwrite`)) | REQ.
- **Stray acks**: `mem_ack` in IDLE or DONE is ignored.
- **Reset values**: state IDLE, `readdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `err`=0.
- **Reset mid-transaction**: the FSM aborts to IDLE and the next cycle's bus outputs are 0. A late `mem_ack` is ignored.

## Timing
- Access detected at cycle N: `stall`=1 at N; `mem_req`=1 from N+1.
- `mem_ack` at cycle M (M ≥ N+1): DONE at M+1 with `stall`=0 and `readdata` valid.
- Minimum access: 3 cycles (2 stalled, 1 DONE).
- Misaligned access: 2 cycles (IDLE stalled, DONE).
- Non-memory instruction in IDLE: `stall`=0, zero added latency.

## Configuration
- `DMEM_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT+1)` clears on entry to REQ and increments each REQ cycle.
  - When it reaches `TIMEOUT` without `mem_ack`: drop `mem_req`, pulse `err`, `readdata`=0, go to DONE.
  - An ack arriving in the same cycle as the limit wins.
- Not defined: no counter is built, and REQ waits indefinitely for `mem_ack`.

## Structure
- Shared package `dmem_pkg`:
  - state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2);
  - `DMEM_ALIGN_MASK` = 2'b11.
- One optional sub-module, `dmem_timer`: the timeout counter, instantiated only under `DMEM_TIMEOUT_EN`.
- Everything else is flat.

## Test plan
- **Aligned load**: reset, then `memread`=1 with `addr`=0x100 and `mem_ack` at N+1 carrying 0xDEADBEEF → `stall`=1 at N and N+1, `mem_addr`=0x100 with `mem_we`=0, `readdata`=0xDEADBEEF and `stall`=0 at N+2.
- **Store with slow ack**: `memwrite`=1, `addr`=0x204, `writedata`=0x12345678, ack at N+5 → `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` held stable N+1..N+5, `stall` high N..N+5, `readdata` unchanged.
- **Misaligned load**: `addr`=0x102 with `memread` → `mem_req` never asserts, `err` pulses at N+1, `readdata`=0, `stall` drops at N+1.
- **Read and write together**: `memread`=`memwrite`=1 → `mem_we`=1 (write performed).
- **Back-to-back loads**: two consecutive load instructions → second request seen in the IDLE cycle after DONE; no cycle is lost or duplicated.
- **Reset mid-REQ**: assert `reset` at N+2 before any ack, then pulse `mem_ack` at N+3 → all outputs 0 and state IDLE; the late ack causes no capture.
- **Timeout (`DMEM_TIMEOUT_EN`, `TIMEOUT`=4)**: no ack → `err` pulses and `stall` drops 4 REQ cycles after `mem_req` rises.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: FSM state encoding and
// the word-alignment mask applied to byte addresses from the datapath.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

    localparam logic [1:0] DMEM_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return |(low_bits & DMEM_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Request timeout counter: held at zero outside REQ, counts REQ cycles and
// flags the cycle in which the count reaches TIMEOUT.
module dmem_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The count would reach TIMEOUT on this edge, so the limit is hit now.
    assign expired = run && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller between the datapath and a req/ack bus.
// Optional request timeout is built only when DMEM_TIMEOUT_EN is defined.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memread,
    input  logic          memwrite,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] writedata,
    output logic [DW-1:0] readdata,
    output logic          stall,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    dmem_state_e   state_q, state_d;
    logic [DW-1:0] readdata_q, readdata_d;
    logic          err_q, err_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic access;
    logic misaligned;
    logic timeout_hit;

    assign access     = memread | memwrite;
    assign misaligned = is_misaligned(addr[1:0]);

`ifdef DMEM_TIMEOUT_EN
    dmem_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (state_q == ST_REQ),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // A zero limit is meaningless; no timer logic hangs off this block.
    if (TIMEOUT < 1) begin : g_timeout_floor
    end

    // Hold the datapath from the detecting IDLE cycle until DONE.
    assign stall = ((state_q == ST_IDLE) && access) || (state_q == ST_REQ);

    always_comb begin
        state_d     = state_q;
        readdata_d  = readdata_q;
        err_d       = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        err_d      = 1'b1;
                        readdata_d = '0;
                        state_d    = ST_DONE;
                    end else begin
                        // memwrite wins when both strobes are set.
                        mem_req_d   = 1'b1;
                        mem_we_d    = memwrite;
                        mem_addr_d  = addr & ~AW'(DMEM_ALIGN_MASK);
                        mem_wdata_d = writedata;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        readdata_d = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (timeout_hit) begin
                    mem_req_d  = 1'b0;
                    err_d      = 1'b1;
                    readdata_d = '0;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            readdata_q  <= '0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            readdata_q  <= readdata_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign readdata  = readdata_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: per-cycle vector table plus hand sequences
// for reset during a request and (when built with the macro) the timeout.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite, mem_ack;
  logic [31:0] addr, writedata, mem_rdata;
  logic [31:0] readdata, mem_addr, mem_wdata;
  logic        stall, err, mem_req, mem_we;

  int checks = 0;
  int errors = 0;

  dmem_ctrl #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [31:0] a, wd;
    logic        ack;
    logic [31:0] rdat;
    logic        e_stall, e_req, e_we;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rd, wr, input logic [31:0] a, wd,
                              input logic ack, input logic [31:0] rdat,
                              input logic es, er, ewe,
                              input logic [31:0] ea, ewd, erd, input logic eerr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.ack = ack; v.rdat = rdat;
    v.e_stall = es; v.e_req = er; v.e_we = ewe;
    v.e_addr = ea; v.e_wdata = ewd; v.e_rdata = erd; v.e_err = eerr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Drives one cycle of inputs at the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic rst, rd, wr, input logic [31:0] a, wd,
                       input logic ack, input logic [31:0] rdat);
    @(negedge clk);
    reset = rst; memread = rd; memwrite = wr; addr = a; writedata = wd;
    mem_ack = ack; mem_rdata = rdat;
    #1;
  endtask

  task automatic chk_all(input string tag, input logic es, er, ewe,
                         input logic [31:0] ea, ewd, erd, input logic eerr);
    chk({tag, " stall"},     32'(stall),     32'(es));
    chk({tag, " mem_req"},   32'(mem_req),   32'(er));
    chk({tag, " mem_we"},    32'(mem_we),    32'(ewe));
    chk({tag, " mem_addr"},  mem_addr,       ea);
    chk({tag, " mem_wdata"}, mem_wdata,      ewd);
    chk({tag, " readdata"},  readdata,       erd);
    chk({tag, " err"},       32'(err),       32'(eerr));
  endtask

  initial begin
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; addr = '0; writedata = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    //   rd wr addr          wdata         ack rdata          | st rq we mem_addr      mem_wdata     readdata      err
    // aligned load, ack at N+1
    add(1, 0, 32'h100,     32'h0,        0, 32'h0,          1, 0, 0, 32'h0,   32'h0,        32'h0,        0);
    add(1, 0, 32'h100,     32'h0,        1, 32'hDEADBEEF,   1, 1, 0, 32'h100, 32'h0,        32'h0,        0);
    add(1, 0, 32'h100,     32'h0,        0, 32'h0,          0, 0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0);
    add(0, 0, 32'h0,       32'h0,        0, 32'h0,          0, 0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0);
    // store, ack at N+5, bus outputs stable while waiting
    add(0, 1, 32'h204,     32'h12345678, 0, 32'h0,          1, 0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0);
    for (int i = 0; i < 4; i++)
      add(0, 1, 32'h204,   32'h12345678, 0, 32'h0,          1, 1, 1, 32'h204, 32'h12345678, 32'hDEADBEEF, 0);
    add(0, 1, 32'h204,     32'h12345678, 1, 32'hFFFFFFFF,   1, 1, 1, 32'h204, 32'h12345678, 32'hDEADBEEF, 0);
    add(0, 1, 32'h204,     32'h12345678, 0, 32'h0,          0, 0, 1, 32'h204, 32'h12345678, 32'hDEADBEEF, 0);
    add(0, 0, 32'h0,       32'h0,        0, 32'h0,          0, 0, 1, 32'h204, 32'h12345678, 32'hDEADBEEF, 0);
    // misaligned load
    add(1, 0, 32'h102,     32'h0,        0, 32'h0,          1, 0, 1, 32'h204, 32'h12345678, 32'hDEADBEEF, 0);
    add(1, 0, 32'h102,     32'h0,        0, 32'h0,          0, 0, 1, 32'h204, 32'h12345678, 32'h0,        1);
    add(0, 0, 32'h0,       32'h0,        0, 32'h0,          0, 0, 1, 32'h204, 32'h12345678, 32'h0,        0);
    // misaligned store, then a stray ack in IDLE
    add(0, 1, 32'h307,     32'hBBBB,     0, 32'h0,          1, 0, 1, 32'h204, 32'h12345678, 32'h0,        0);
    add(0, 1, 32'h307,     32'hBBBB,     0, 32'h0,          0, 0, 1, 32'h204, 32'h12345678, 32'h0,        1);
    add(0, 0, 32'h0,       32'h0,        1, 32'h99999999,   0, 0, 1, 32'h204, 32'h12345678, 32'h0,        0);
    // read and write together -> write
    add(1, 1, 32'h300,     32'hAAAA5555, 0, 32'h0,          1, 0, 1, 32'h204, 32'h12345678, 32'h0,        0);
    add(1, 1, 32'h300,     32'hAAAA5555, 1, 32'h11111111,   1, 1, 1, 32'h300, 32'hAAAA5555, 32'h0,        0);
    add(1, 1, 32'h300,     32'hAAAA5555, 0, 32'h0,          0, 0, 1, 32'h300, 32'hAAAA5555, 32'h0,        0);
    add(0, 0, 32'h0,       32'h0,        0, 32'h0,          0, 0, 1, 32'h300, 32'hAAAA5555, 32'h0,        0);
    // back-to-back loads, stray ack during DONE
    add(1, 0, 32'h400,     32'h0,        0, 32'h0,          1, 0, 1, 32'h300, 32'hAAAA5555, 32'h0,        0);
    add(1, 0, 32'h400,     32'h0,        1, 32'hCAFE0001,   1, 1, 0, 32'h400, 32'h0,        32'h0,        0);
    add(1, 0, 32'h400,     32'h0,        1, 32'h99999999,   0, 0, 0, 32'h400, 32'h0,        32'hCAFE0001, 0);
    add(1, 0, 32'h404,     32'h0,        0, 32'h0,          1, 0, 0, 32'h400, 32'h0,        32'hCAFE0001, 0);
    add(1, 0, 32'h404,     32'h0,        1, 32'hCAFE0002,   1, 1, 0, 32'h404, 32'h0,        32'hCAFE0001, 0);
    add(1, 0, 32'h404,     32'h0,        0, 32'h0,          0, 0, 0, 32'h404, 32'h0,        32'hCAFE0002, 0);
    add(0, 0, 32'h0,       32'h0,        0, 32'h0,          0, 0, 0, 32'h404, 32'h0,        32'hCAFE0002, 0);

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    chk("reset state", 32'(dut.state_q), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(0, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].ack, vecs[i].rdat);
      chk_all($sformatf("row%0d", i), vecs[i].e_stall, vecs[i].e_req, vecs[i].e_we,
              vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_rdata, vecs[i].e_err);
    end

    // reset in the middle of a request, then a late ack
    drive(0, 1, 0, 32'h500, 32'h0, 0, 32'h0);
    chk("midrst N stall", 32'(stall), 32'd1);
    drive(0, 1, 0, 32'h500, 32'h0, 0, 32'h0);
    chk("midrst N+1 mem_req", 32'(mem_req), 32'd1);
    chk("midrst N+1 mem_addr", mem_addr, 32'h500);
    drive(1, 1, 0, 32'h500, 32'h0, 0, 32'h0);
    chk("midrst N+2 stall", 32'(stall), 32'd1);
    drive(0, 0, 0, 32'h0, 32'h0, 1, 32'h77777777);
    chk_all("midrst N+3", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    chk("midrst N+3 state", 32'(dut.state_q), 32'd0);
    drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    chk_all("midrst N+4", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    chk("midrst N+4 state", 32'(dut.state_q), 32'd0);

`ifdef DMEM_TIMEOUT_EN
    // ack arriving on the limit cycle wins
    drive(0, 1, 0, 32'h604, 32'h0, 0, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      drive(0, 1, 0, 32'h604, 32'h0, 0, 32'h0);
      chk($sformatf("tack N+%0d stall", c), 32'(stall), 32'd1);
    end
    drive(0, 1, 0, 32'h604, 32'h0, 1, 32'h5A5A5A5A);
    drive(0, 1, 0, 32'h604, 32'h0, 0, 32'h0);
    chk_all("tack done", 0, 0, 0, 32'h604, 32'h0, 32'h5A5A5A5A, 0);
    // no ack: error after 4 REQ cycles
    drive(0, 1, 0, 32'h600, 32'h0, 0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      drive(0, 1, 0, 32'h600, 32'h0, 0, 32'h0);
      chk_all($sformatf("tout N+%0d", c), 1, 1, 0, 32'h600, 32'h0, 32'h5A5A5A5A, 0);
    end
    drive(0, 1, 0, 32'h600, 32'h0, 0, 32'h0);
    chk_all("tout done", 0, 0, 0, 32'h600, 32'h0, 32'h0, 1);
    drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    chk("tout err clear", 32'(err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
